fb_stream_to_axi_writer: RTL and testbench
==========================================

FB_STREAM_TO_AXI_WRITER -- requirements
Module: fb_stream_to_axi_writer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, stream/AXI data width in bits, power of two >= 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI byte-address width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AXI ID width.
REQ-004 SHALL have parameter BURST_LEN, default 16, maximum beats per burst, power of two, 1..256, with BURST_LEN*DATA_WIDTH/8 <= 4096.
REQ-005 SHALL have parameter FIFO_DEPTH_LG, default 5, log2 of the beat FIFO depth, with 2**FIFO_DEPTH_LG >= BURST_LEN.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, synchronous, active-high reset.
REQ-007 SHALL have ports: confAddr in ADDR_WIDTH, destination base byte address; start in 1, begin transfer; busy out 1, transfer active; done out 1, one-cycle completion pulse; error out 1, sticky response error.
REQ-008 SHALL have ports: s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1; s_axis_tdata in DATA_WIDTH. These carry the committed framebuffer stream.
REQ-009 SHALL have AXI4 write ports: awid, awaddr, awlen(8), awsize(3), awburst(2), awvalid out; awready in; wdata, wstrb, wlast, wvalid out; wready in; bid, bresp(2), bvalid in; bready out.

Function
REQ-010 SHALL use the FSM states IDLE, COLLECT, ADDR, DATA, RESP.
REQ-011 IDLE: s_axis_tready=0 and busy=0; on start=1, latch confAddr with low log2(BURST_LEN*DATA_WIDTH/8) bits forced to 0, clear error, go to COLLECT.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 In every non-IDLE state, until tlast has been accepted, s_axis_tready SHALL equal FIFO-not-full, and accepted beats SHALL be pushed with zero bubble.
REQ-014 COLLECT: when FIFO count >= BURST_LEN, or when tlast has been accepted and the FIFO is non-empty, latch burstBeats=min(count,BURST_LEN) and go to ADDR.
REQ-015 ADDR: awvalid=1, awaddr=current address, awlen=burstBeats-1, awsize=log2(DATA_WIDTH/8), awburst=INCR (01), awid=0; go to DATA on awready.
REQ-016 awvalid SHALL remain asserted and the AW fields SHALL remain stable until awready.
REQ-017 DATA: wvalid=1 and wdata=FIFO head; pop on wvalid&&wready; wlast=1 on beat burstBeats; wstrb SHALL be all ones; go to RESP after the last handshake.
REQ-018 RESP: bready=1; on bvalid, OR (bresp!=00) into error and add burstBeats*DATA_WIDTH/8 to the address.
REQ-019 After RESP, if tlast has been accepted and the FIFO is empty, pulse done=1 for one cycle and go to IDLE; otherwise go to COLLECT.
REQ-020 Only one burst SHALL be outstanding; AW SHALL precede its W beats; W SHALL NOT start before the AW handshake.
REQ-021 Beats arriving after tlast SHALL NOT be accepted (tready=0) until the next start.
REQ-022 An address counter wrap at 2**ADDR_WIDTH SHALL wrap modulo without error.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 On reset, SHALL go to IDLE and empty the FIFO; awvalid, wvalid, wlast, bready, s_axis_tready, busy, done and error SHALL all be 0 from the next cycle, including mid-burst.
REQ-025 Reset SHALL take priority over start in the same cycle.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, and a function computing awsize from DATA_WIDTH.
REQ-027 The beat buffer SHALL be a separate synchronous FIFO sub-module, fb_stream_fifo, with push/pop/full/empty/count and first-word-fall-through output.
REQ-028 The top level SHALL contain only the FSM, the address/beat counters and the AXI output registers.

Verification (DATA_WIDTH=32, BURST_LEN=16)
REQ-029 confAddr=0x1000_0000, 32 beats, tlast on beat 32 -> two AW: 0x1000_0000 and 0x1000_0040, each with awlen=15; wlast on W beats 16 and 32; done pulses once; error=0.
REQ-030 20 beats -> AW 0x1000_0000 with awlen=15, then AW 0x1000_0040 with awlen=3; wdata order equals the input order.
REQ-031 A single beat with tlast -> one AW with awlen=0 and wlast=1 on that beat, then done.
REQ-032 wready toggling 1/0 every cycle and awready delayed 5 cycles -> data intact, with no wvalid before the AW handshake.
REQ-033 bresp=2'b10 on the first of two bursts -> the transfer completes and error=1 stays set until the next start.
REQ-034 Reset asserted on the 3rd W beat -> next cycle all valids are 0 and busy=0; a new start with 16 beats completes normally.

Source files
------------

// File: rtl/fb_stream_to_axi_writer_pkg.sv
// Shared FSM encoding and AXI constants for the framebuffer
// stream-to-AXI writer.
package fb_stream_to_axi_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ADDR,
        DATA,
        RESP
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/fb_stream_fifo.sv
// Synchronous first-word-fall-through beat FIFO; the head word is
// visible on dout_o whenever empty_o is low.
module fb_stream_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH_LG = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    din_i,
    input  logic                pop_i,
    output logic [WIDTH-1:0]    dout_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LG:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_LG;
    localparam int CW    = DEPTH_LG + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q;
    logic [CW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LG-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LG-1:0]] <= din_i;
    end

endmodule

// File: rtl/fb_stream_to_axi_writer.sv
// Buffers a framebuffer stream and writes it to memory as
// aligned AXI4 INCR bursts, one burst outstanding at a time.
module fb_stream_to_axi_writer
    import fb_stream_to_axi_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int BURST_LEN     = 16,
    parameter int FIFO_DEPTH_LG = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   confAddr,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int CW          = FIFO_DEPTH_LG + 1;
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [2:0] SIZE = axi_size(DATA_WIDTH);
    localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);
    localparam logic [8:0] BL_B = 9'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'(BURST_BYTES - 1);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            beats_q, beats_d;
    logic [8:0]            wcnt_q, wcnt_d;
    logic                  last_q, last_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  unused_bid;

    fb_stream_fifo #(
        .WIDTH    (DATA_WIDTH),
        .DEPTH_LG (FIFO_DEPTH_LG)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (s_axis_tdata),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign unused_bid    = ^bid;
    assign s_axis_tready = (state_q != IDLE) && !last_q && !fifo_full;
    assign fifo_push     = s_axis_tvalid && s_axis_tready;
    assign fifo_pop      = (state_q == DATA) && wready;

    assign awvalid = (state_q == ADDR);
    assign awaddr  = addr_q;
    assign awlen   = 8'(beats_q - 9'd1);
    assign awsize  = SIZE;
    assign awburst = AXI_BURST_INCR;
    assign awid    = '0;
    assign wvalid  = (state_q == DATA);
    assign wdata   = fifo_dout;
    assign wstrb   = '1;
    assign wlast   = wvalid && (wcnt_q == beats_q - 9'd1);
    assign bready  = (state_q == RESP);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign error   = error_q;

    // Next-state, burst sizing and address advance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        wcnt_d  = wcnt_q;
        error_d = error_q;
        done_d  = 1'b0;
        last_d  = last_q | (fifo_push && s_axis_tlast);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = confAddr & ALIGN_MASK;
                    error_d = 1'b0;
                    last_d  = 1'b0;
                    wcnt_d  = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (fifo_count >= BL_C || (last_q && !fifo_empty)) begin
                    beats_d = (fifo_count >= BL_C) ? BL_B : 9'(fifo_count);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (awready) state_d = DATA;
            end
            DATA: begin
                if (wready) begin
                    if (wlast) begin
                        wcnt_d  = '0;
                        state_d = RESP;
                    end else begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                end
            end
            RESP: begin
                if (bvalid) begin
                    error_d = error_q | (bresp != AXI_RESP_OKAY);
                    addr_d  = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
                    if (last_q && fifo_empty) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            wcnt_q  <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_stream_to_axi_writer.sv
// Randomized bench for fb_stream_to_axi_writer with a burst-level
// reference model and a per-cycle AXI compare process.
module tb_fb_stream_to_axi_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int BL = 16;
    localparam int LIMIT = 4000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] confAddr = '0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wlast, wvalid;
    logic          wready = 1'b0;
    logic [IW-1:0] bid = '0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    always #5 clk = ~clk;

    fb_stream_to_axi_writer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .BURST_LEN     (BL),
        .FIFO_DEPTH_LG (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .confAddr      (confAddr),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .awid          (awid),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awsize        (awsize),
        .awburst       (awburst),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bid           (bid),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready)
    );

    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        if (act === exp_v) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask

    // Reference model: expected bursts and beats of the current transfer.
    logic [31:0] exp_addr_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_last_q[$];
    bit          exp_err;
    logic [31:0] log_addr[$];
    int          log_len[$];
    int          done_cnt;

    bit          burst_open = 0;
    bit          w_open = 0;
    bit          aw_pend = 0;
    logic [31:0] aw_pend_addr;
    logic [7:0]  aw_pend_len;

    // Compare DUT outputs against the model once they have settled.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            burst_open = 0;
            w_open = 0;
            aw_pend = 0;
        end else begin
            if (aw_pend) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, aw_pend_addr);
                chk("aw_hold_len", awlen, aw_pend_len);
            end
            if (awvalid && awready) begin
                chk("aw_one_outstanding", burst_open, 0);
                chk("aw_expected", exp_addr_q.size() > 0, 1);
                if (exp_addr_q.size() > 0) begin
                    chk("awaddr", awaddr, exp_addr_q.pop_front());
                    chk("awlen", awlen, exp_len_q.pop_front());
                end
                chk("awsize", awsize, 2);
                chk("awburst", awburst, 1);
                chk("awid", awid, 0);
                log_addr.push_back(awaddr);
                log_len.push_back(int'(awlen));
                burst_open = 1;
                w_open = 1;
            end
            if (wvalid) chk("w_after_aw", w_open, 1);
            if (wvalid && wready) begin
                chk("w_expected", exp_data_q.size() > 0, 1);
                if (exp_data_q.size() > 0) begin
                    chk("wdata", wdata, exp_data_q.pop_front());
                    chk("wlast", wlast, exp_last_q.pop_front());
                end
                chk("wstrb", wstrb, 4'hF);
                if (wlast) w_open = 0;
            end
            if (bvalid && bready) burst_open = 0;
            if (done) begin
                done_cnt++;
                chk("done_err", error, exp_err);
                chk("done_busy", busy, 0);
                chk("done_w_drained", exp_data_q.size(), 0);
                chk("done_aw_drained", exp_addr_q.size(), 0);
            end
            aw_pend = awvalid && !awready;
            aw_pend_addr = awaddr;
            aw_pend_len = awlen;
        end
    end

    task automatic check_all_low(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_error"}, error, 0);
        chk({nm, "_awvalid"}, awvalid, 0);
        chk({nm, "_wvalid"}, wvalid, 0);
        chk({nm, "_wlast"}, wlast, 0);
        chk({nm, "_bready"}, bready, 0);
        chk({nm, "_tready"}, s_axis_tready, 0);
    endtask

    // One transfer: model setup, stream source and AXI slave per cycle.
    task automatic run_xfer(input logic [31:0] base, input int n,
                            input int errb, input int awd,
                            input int wmode, input bit rnd,
                            input int rst_at_w);
        logic [31:0] d[$];
        logic [31:0] a;
        int idx, cyc, aw_wait, b_pend, bidx, w_hs;
        bit stop;
        a = base & 32'hFFFF_FFC0;
        exp_err = 0;
        log_addr.delete();
        log_len.delete();
        for (int k = 0; k * BL < n; k++) begin
            int left;
            left = n - k * BL;
            exp_addr_q.push_back(a + 32'(k * 64));
            exp_len_q.push_back((left > BL ? BL : left) - 1);
            if (k == errb) exp_err = 1;
        end
        for (int i = 0; i < n; i++) begin
            d.push_back($urandom);
            exp_data_q.push_back(d[i]);
            exp_last_q.push_back((i % BL == BL - 1) || (i == n - 1));
        end
        done_cnt = 0;
        idx = 0; cyc = 0; aw_wait = 0; b_pend = 0; bidx = 0; w_hs = 0;
        stop = 0;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 1) || (rnd && cyc % 37 == 0 && busy);
            confAddr = (cyc == 1) ? base : $urandom;
            if (idx >= n) s_axis_tvalid = 1'($urandom_range(1));
            else s_axis_tvalid = !rnd || ($urandom_range(3) != 0);
            s_axis_tdata = (idx < n) ? d[idx] : $urandom;
            s_axis_tlast = (idx == n - 1) ||
                           (idx >= n && $urandom_range(1) == 1);
            aw_wait = awvalid ? aw_wait + 1 : 0;
            awready = (aw_wait > awd) && (!rnd || $urandom_range(1) == 1);
            if (wmode == 0) wready = 1'b1;
            else if (wmode == 1) wready = !wready;
            else wready = 1'($urandom_range(1));
            bvalid = (b_pend > 0) && (!rnd || $urandom_range(1) == 1);
            bresp = (bidx == errb) ? 2'b10 : 2'b00;
            if (rst_at_w > 0 && w_hs == rst_at_w - 1 && wvalid && wready) begin
                reset = 1'b1;
                stop = 1;
            end
            #1;
            if (s_axis_tvalid && s_axis_tready) begin
                chk("post_tlast_accept", idx < n, 1);
                idx++;
            end
            if (wvalid && wready) begin
                w_hs++;
                if (wlast) b_pend++;
            end
            if (bvalid && bready) begin
                b_pend--;
                bidx++;
            end
            if (done) stop = 1;
            if (cyc >= LIMIT && !stop) begin
                n_fail++;
                $display("FAIL xfer_timeout: got no done after %0d cycles want done", cyc);
                stop = 1;
            end
        end
        start = 1'b0;
        s_axis_tvalid = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        if (rst_at_w > 0) begin
            exp_addr_q.delete();
            exp_len_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
            @(negedge clk);
            #1;
            check_all_low("mid_reset");
            reset = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
            #3;
            chk("done_once", done_cnt, 1);
            chk("idle_busy", busy, 0);
            chk("sticky_err", error, exp_err);
            exp_addr_q.delete();
            exp_len_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_all_low("reset");
        reset = 1'b0;

        run_xfer(32'h1000_0000, 32, -1, 0, 0, 0, 0);
        chk("t32_aw_cnt", log_addr.size(), 2);
        chk("t32_aw0", log_addr[0], 32'h1000_0000);
        chk("t32_aw1", log_addr[1], 32'h1000_0040);
        chk("t32_len0", log_len[0], 15);
        chk("t32_len1", log_len[1], 15);

        run_xfer(32'h1000_0000, 20, -1, 0, 0, 0, 0);
        chk("t20_aw1", log_addr[1], 32'h1000_0040);
        chk("t20_len0", log_len[0], 15);
        chk("t20_len1", log_len[1], 3);

        run_xfer(32'h1000_0000, 1, -1, 0, 0, 0, 0);
        chk("t1_aw_cnt", log_addr.size(), 1);
        chk("t1_len0", log_len[0], 0);

        run_xfer(32'h2000_0010, 24, -1, 5, 1, 0, 0);
        chk("slow_aw0", log_addr[0], 32'h2000_0000);

        run_xfer(32'h1000_0000, 32, 0, 0, 0, 0, 0);
        chk("berr_sticky", error, 1);

        run_xfer(32'h3000_0000, 32, -1, 0, 0, 0, 3);
        run_xfer(32'h3000_0000, 16, -1, 0, 0, 0, 0);
        chk("after_rst_cnt", log_addr.size(), 1);
        chk("after_rst_len", log_len[0], 15);

        run_xfer(32'hFFFF_FFC5, 20, -1, 0, 0, 0, 0);
        chk("wrap_aw0", log_addr[0], 32'hFFFF_FFC0);
        chk("wrap_aw1", log_addr[1], 32'h0000_0000);

        for (int r = 0; r < 15; r++) begin
            run_xfer($urandom, int'($urandom_range(1, 70)),
                     int'($urandom_range(0, 6)) - 1,
                     int'($urandom_range(0, 4)), 2, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
